// File: rtl/irq_sequencer_if.sv
// Handshake bundle between the interrupt sequencer and the control unit.
// The control-unit side (master) drives the request/stack inputs; the
// sequencer (slave) drives the interrupt pulses and status outputs.
interface irq_sequencer_if #(
  parameter int unsigned DEPTH_W = 3
);
  logic               irq_ext;
  logic               timer_tick;
  logic               sub_call;
  logic               sub_ret;
  logic               mask_we;
  logic [1:0]         mask_din;
  logic               interrupcion;
  logic               clock_out;
  logic               busy;
  logic [1:0]         pending;
  logic [DEPTH_W-1:0] depth;
  logic               depth_err;

  modport master (
    output irq_ext, timer_tick, sub_call, sub_ret, mask_we, mask_din,
    input  interrupcion, clock_out, busy, pending, depth, depth_err
  );

  modport slave (
    input  irq_ext, timer_tick, sub_call, sub_ret, mask_we, mask_din,
    output interrupcion, clock_out, busy, pending, depth, depth_err
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: synchronizes the external pin, latches masked
// requests as pending, issues them one at a time as single-cycle pulses and
// holds off further requests until the service routine's own final return.
module irq_sequencer #(
  parameter int unsigned DEPTH_W  = 3,
  parameter logic [1:0]  MASK_RST = 2'b00
) (
  input  logic           clk,
  input  logic           reset,
  irq_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state_q, state_d;
  logic               src_ext_q, src_ext_d;
  logic [1:0]         pending_q, pending_d;
  logic [1:0]         mask_q, mask_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               derr_q, derr_d;
  logic               intr_q, intr_d;
  logic               clk_out_q, clk_out_d;
  logic               busy_q, busy_d;

  logic               sync1_q, sync2_q, hist_q;
  logic [2:0]         vld_q;
  logic               ext_edge;
  logic [1:0]         set_vec;
  logic [1:0]         clr_vec;

  // Two-flop synchronizer plus history flop; vld_q tracks which stages hold
  // real post-reset pin samples so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      sync1_q <= bus.irq_ext;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  assign ext_edge = sync2_q & ~hist_q & vld_q[2];
  // Events are filtered by the mask as it stood before any same-cycle write.
  assign set_vec  = {ext_edge & mask_q[1], bus.timer_tick & mask_q[0]};

  // Next-state: sequencing FSM, pending latch, depth tracking and pulse outputs.
  always_comb begin
    state_d   = state_q;
    src_ext_d = src_ext_q;
    clr_vec   = '0;
    depth_d   = depth_q;
    derr_d    = derr_q;
    mask_d    = bus.mask_we ? bus.mask_din : mask_q;

    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          state_d = ISSUE;
          if (pending_q[1]) begin
            src_ext_d = 1'b1;
            clr_vec   = 2'b10;
          end else begin
            src_ext_d = 1'b0;
            clr_vec   = 2'b01;
          end
        end
      end
      ISSUE: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (bus.sub_call && !bus.sub_ret) begin
          if (depth_q == DEPTH_MAX) begin
            derr_d = 1'b1;
          end else begin
            depth_d = depth_q + DEPTH_W'(1);
          end
        end else if (bus.sub_ret && !bus.sub_call) begin
          if (depth_q != '0) begin
            depth_d = depth_q - DEPTH_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set is applied after clear so a same-cycle event wins.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    intr_d    = (state_d == ISSUE) &&  src_ext_d;
    clk_out_d = (state_d == ISSUE) && !src_ext_d;
    busy_d    = (state_d == SERVICE);
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_ext_q <= 1'b0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      depth_q   <= '0;
      derr_q    <= 1'b0;
      intr_q    <= 1'b0;
      clk_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ext_q <= src_ext_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      depth_q   <= depth_d;
      derr_q    <= derr_d;
      intr_q    <= intr_d;
      clk_out_q <= clk_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.interrupcion = intr_q;
  assign bus.clock_out    = clk_out_q;
  assign bus.busy         = busy_q;
  assign bus.pending      = pending_q;
  assign bus.depth        = depth_q;
  assign bus.depth_err    = derr_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: a per-cycle reference model of the sequencing
// rules checked every cycle, plus hand-computed checkpoints.
module tb_irq_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  irq_sequencer_if #(.DEPTH_W(3)) bus_if ();

  irq_sequencer #(
    .DEPTH_W  (3),
    .MASK_RST (2'b00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_valid;
  bit       samp[$];      // post-reset pin samples, oldest first
  int       m_phase;      // 0 waiting, 1 issuing, 2 servicing
  bit       m_src_ext;
  bit [1:0] m_pend;
  bit [1:0] m_mask;
  int       m_depth;
  bit       m_derr;

  always @(posedge clk) begin
    bit       ev_ext;
    bit [1:0] ev;
    if (reset) begin
      m_valid = 1'b1;
      samp.delete();
      m_phase = 0; m_src_ext = 1'b0; m_pend = 2'b00; m_mask = 2'b00;
      m_depth = 0; m_derr = 1'b0;
    end else if (m_valid) begin
      // A rise seen at edge t-2 against edge t-3 lands in pending at edge t.
      ev_ext = 1'b0;
      if (samp.size() == 3) ev_ext = samp[1] && !samp[0];
      samp.push_back(bus_if.irq_ext);
      if (samp.size() > 3) void'(samp.pop_front());
      ev = {ev_ext && m_mask[1], bus_if.timer_tick && m_mask[0]};
      if (m_phase == 0) begin
        if (m_pend != 2'b00) begin
          m_phase   = 1;
          m_src_ext = m_pend[1];
          if (m_src_ext) m_pend[1] = 1'b0; else m_pend[0] = 1'b0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (bus_if.sub_call && !bus_if.sub_ret) begin
          if (m_depth == 7) m_derr = 1'b1; else m_depth = m_depth + 1;
        end else if (bus_if.sub_ret && !bus_if.sub_call) begin
          if (m_depth > 0) m_depth = m_depth - 1; else m_phase = 0;
        end
      end
      m_pend = m_pend | ev;
      if (bus_if.mask_we) m_mask = bus_if.mask_din;
    end
  end

  // Compare process: DUT outputs against the model every cycle after reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_interrupcion", int'(bus_if.interrupcion), int'(m_phase == 1 &&  m_src_ext));
      chk("m_clock_out",    int'(bus_if.clock_out),    int'(m_phase == 1 && !m_src_ext));
      chk("m_busy",         int'(bus_if.busy),         int'(m_phase == 2));
      chk("m_pending",      int'(bus_if.pending),      int'(m_pend));
      chk("m_depth",        int'(bus_if.depth),        m_depth);
      chk("m_depth_err",    int'(bus_if.depth_err),    int'(m_derr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [1:0] v);
    bus_if.mask_we  = 1'b1;
    bus_if.mask_din = v;
    step(1);
    bus_if.mask_we  = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_valid = 1'b0;
    reset = 1'b1;
    bus_if.irq_ext = 1'b0; bus_if.timer_tick = 1'b0;
    bus_if.sub_call = 1'b0; bus_if.sub_ret = 1'b0;
    bus_if.mask_we = 1'b0; bus_if.mask_din = 2'b00;
    step(3);
    reset = 1'b0;
    chk("rst_interrupcion", int'(bus_if.interrupcion), 0);
    chk("rst_clock_out",    int'(bus_if.clock_out), 0);
    chk("rst_busy",         int'(bus_if.busy), 0);
    chk("rst_pending",      int'(bus_if.pending), 0);
    chk("rst_depth",        int'(bus_if.depth), 0);
    chk("rst_depth_err",    int'(bus_if.depth_err), 0);
    step(2);

    // Timer request; calls in IDLE and ISSUE are ignored.
    write_mask(2'b11);
    bus_if.sub_call = 1'b1; step(1); bus_if.sub_call = 1'b0;
    chk("idle_call_depth", int'(bus_if.depth), 0);
    bus_if.timer_tick = 1'b1; step(1); bus_if.timer_tick = 1'b0;
    chk("tick_pending", int'(bus_if.pending), 1);
    chk("tick_no_pulse_yet", int'(bus_if.clock_out), 0);
    bus_if.sub_call = 1'b1; step(1);
    chk("tick_clock_out", int'(bus_if.clock_out), 1);
    chk("tick_pending_cleared", int'(bus_if.pending), 0);
    chk("tick_not_busy_in_issue", int'(bus_if.busy), 0);
    step(1); bus_if.sub_call = 1'b0;
    chk("tick_clock_out_single", int'(bus_if.clock_out), 0);
    chk("tick_busy", int'(bus_if.busy), 1);
    chk("issue_call_ignored", int'(bus_if.depth), 0);
    bus_if.sub_ret = 1'b1; step(1); bus_if.sub_ret = 1'b0;
    chk("tick_ret_busy", int'(bus_if.busy), 0);
    step(2);

    // Both sources requested during service: ext first, then timer.
    bus_if.timer_tick = 1'b1; step(1); bus_if.timer_tick = 1'b0;
    step(2);
    bus_if.irq_ext = 1'b1; bus_if.timer_tick = 1'b1; step(1); bus_if.timer_tick = 1'b0;
    chk("both_pending_t", int'(bus_if.pending), 1);
    step(2);
    chk("both_pending_11", int'(bus_if.pending), 3);
    chk("both_busy", int'(bus_if.busy), 1);
    bus_if.sub_ret = 1'b1; step(1); bus_if.sub_ret = 1'b0;
    chk("both_exit_busy", int'(bus_if.busy), 0);
    chk("both_idle_no_pulse", int'(bus_if.interrupcion), 0);
    step(1);
    chk("both_ext_first", int'(bus_if.interrupcion), 1);
    chk("both_no_timer_pulse", int'(bus_if.clock_out), 0);
    chk("both_pending_01", int'(bus_if.pending), 1);
    step(3);
    chk("both_pending_held", int'(bus_if.pending), 1);
    bus_if.sub_ret = 1'b1; step(1); bus_if.sub_ret = 1'b0;
    chk("both_gap_clock_out", int'(bus_if.clock_out), 0);
    chk("both_gap_busy", int'(bus_if.busy), 0);
    step(1);
    chk("both_timer_second", int'(bus_if.clock_out), 1);
    chk("both_pending_empty", int'(bus_if.pending), 0);
    step(1);

    // Call depth inside service.
    bus_if.sub_call = 1'b1; step(1);
    chk("depth_1", int'(bus_if.depth), 1);
    step(1);
    chk("depth_2", int'(bus_if.depth), 2);
    bus_if.sub_ret = 1'b1; step(1); bus_if.sub_call = 1'b0;
    chk("depth_call_ret_same", int'(bus_if.depth), 2);
    step(1);
    chk("depth_back_1", int'(bus_if.depth), 1);
    step(1);
    chk("depth_back_0", int'(bus_if.depth), 0);
    chk("depth_still_busy", int'(bus_if.busy), 1);
    step(1); bus_if.sub_ret = 1'b0;
    chk("depth_final_ret", int'(bus_if.busy), 0);

    // Masked external edge is discarded; unmasking does not replay it.
    bus_if.irq_ext = 1'b0; step(4);
    write_mask(2'b01);
    bus_if.irq_ext = 1'b1; step(6);
    chk("masked_pending", int'(bus_if.pending), 0);
    chk("masked_no_pulse", int'(bus_if.interrupcion), 0);
    write_mask(2'b11); step(5);
    chk("unmask_no_replay", int'(bus_if.pending), 0);
    bus_if.irq_ext = 1'b0; step(4);
    bus_if.irq_ext = 1'b1; step(1);
    step(1);
    chk("ext_k1_pending", int'(bus_if.pending), 0);
    step(1);
    chk("ext_k2_pending", int'(bus_if.pending), 2);
    step(1);
    chk("ext_k3_interrupcion", int'(bus_if.interrupcion), 1);
    step(1);
    chk("ext_service_busy", int'(bus_if.busy), 1);

    // Depth saturation and sticky error.
    bus_if.sub_call = 1'b1; step(7);
    chk("sat_depth_7", int'(bus_if.depth), 7);
    chk("sat_no_err_yet", int'(bus_if.depth_err), 0);
    step(1); bus_if.sub_call = 1'b0;
    chk("sat_depth_hold", int'(bus_if.depth), 7);
    chk("sat_err", int'(bus_if.depth_err), 1);

    // Clearing the mask keeps an already-pending request.
    bus_if.timer_tick = 1'b1; step(1); bus_if.timer_tick = 1'b0;
    write_mask(2'b00);
    chk("mask_clear_keeps_pending", int'(bus_if.pending), 1);
    bus_if.sub_ret = 1'b1; step(7);
    chk("unwind_depth_0", int'(bus_if.depth), 0);
    chk("unwind_busy", int'(bus_if.busy), 1);
    step(1); bus_if.sub_ret = 1'b0;
    chk("unwind_exit", int'(bus_if.busy), 0);
    chk("err_sticky", int'(bus_if.depth_err), 1);
    step(1);
    chk("kept_pending_issued", int'(bus_if.clock_out), 1);
    step(1);

    // Reset during service with an external request pending.
    write_mask(2'b11);
    bus_if.irq_ext = 1'b0; step(3);
    bus_if.irq_ext = 1'b1; step(4);
    chk("pre_reset_pending", int'(bus_if.pending), 2);
    chk("pre_reset_busy", int'(bus_if.busy), 1);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("mid_rst_busy", int'(bus_if.busy), 0);
    chk("mid_rst_pending", int'(bus_if.pending), 0);
    chk("mid_rst_depth_err", int'(bus_if.depth_err), 0);
    chk("mid_rst_interrupcion", int'(bus_if.interrupcion), 0);
    write_mask(2'b11);
    step(12);
    chk("post_rst_no_edge", int'(bus_if.pending), 0);
    chk("post_rst_idle", int'(bus_if.busy), 0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
